// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller: default geometry and FSM states.
// Ports: none (package).
// Optional feature macro used by importers: MEM_PARITY_EN.
package mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RESP = 3'd2,
    ST_WR   = 3'd3,
    ST_CLR  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between a requester and mem_ctrl.
// Ports: req/wren/clr/address/data from master; q/valid/ack/busy/perr from slave.
// master = requester side, slave = controller side.
interface mem_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              req;
  logic              wren;
  logic              clr;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] q;
  logic              valid;
  logic              ack;
  logic              busy;
  logic              perr;

  modport master (
    output req, wren, clr, address, data,
    input  q, valid, ack, busy, perr
  );

  modport slave (
    input  req, wren, clr, address, data,
    output q, valid, ack, busy, perr
  );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM: write and registered read share one address.
// Ports: clk_i, we_i, addr_i, wdata_i in; rdata_o out (read data one edge after addr_i).
// Contents are deliberately not reset; validity is tracked by the controller.
module mem_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: single read/write transactions plus a full-array clear sweep.
// Ports: clock, reset (async, active-high), bus (mem_ctrl_if.slave).
// Latency: write ack 1 cycle after acceptance, read ack 2 cycles, clear ack after DEPTH cycles.
// Optional MEM_PARITY_EN: stores an even-parity bit per word and reports mismatches on perr.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic          clock,
  input logic          reset,
  mem_ctrl_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] SWEEP_LAST = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [DEPTH-1:0]  vbits_q, vbits_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;
`ifdef MEM_PARITY_EN
  logic              perr_q, perr_d;
`endif

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rdata;

  mem_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clock),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, array control and datapath next values.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    sweep_d   = sweep_q;
    vbits_d   = vbits_q;
    q_d       = q_q;
    valid_d   = valid_q;
    ack_d     = 1'b0;
`ifdef MEM_PARITY_EN
    perr_d    = perr_q;
`endif
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        // Clear has priority; a simultaneous req is dropped, not queued.
        if (bus.clr) begin
          sweep_d = '0;
          state_d = ST_CLR;
        end else if (bus.req) begin
          addr_d  = bus.address;
          data_d  = bus.data;
          state_d = bus.wren ? ST_WR : ST_RD;
        end
      end

      ST_RD: begin
        // Array read issued on addr_q; data lands for RESP.
        state_d = ST_RESP;
      end

      ST_RESP: begin
        // Unwritten words read as zero whatever the stale array holds.
        valid_d = vbits_q[addr_q];
        q_d     = vbits_q[addr_q] ? mem_rdata[DATA_W-1:0] : '0;
`ifdef MEM_PARITY_EN
        perr_d  = vbits_q[addr_q] & (^mem_rdata);
`endif
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end

      ST_WR: begin
        mem_we  = 1'b1;
`ifdef MEM_PARITY_EN
        mem_wdata = {^data_q, data_q};
`else
        mem_wdata = data_q;
`endif
        vbits_d[addr_q] = 1'b1;
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end

      ST_CLR: begin
        // All-zero word has even parity, so zero fill is parity-consistent.
        mem_we   = 1'b1;
        mem_addr = sweep_q;
        vbits_d[sweep_q] = 1'b0;
        if (sweep_q == SWEEP_LAST) begin
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      sweep_q <= '0;
      vbits_q <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
`ifdef MEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      sweep_q <= sweep_d;
      vbits_q <= vbits_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
`ifdef MEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.q     = q_q;
  assign bus.valid = valid_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = (state_q != ST_IDLE);
`ifdef MEM_PARITY_EN
  assign bus.perr  = perr_q;
`else
  assign bus.perr  = 1'b0;
`endif

endmodule
